// File: rtl/voice_mixer_if.sv
// Mixer request/voice bus and mixed-sample result bus between the note players and the codec side.
interface voice_mixer_if #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16
);
    logic                               mix_start;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples;
    logic [2*NUM_VOICES-1:0]            voice_pan;
    logic [NUM_VOICES-1:0]              voice_active;
    logic                               stereo_on;
    logic [2:0]                         atten_shift;

    logic [SAMPLE_WIDTH-1:0]            sample_left;
    logic [SAMPLE_WIDTH-1:0]            sample_right;
    logic [SAMPLE_WIDTH-1:0]            sample_mono;
    logic                               sample_valid;
    logic                               busy;
    logic                               clip;
    logic                               overrun;

    modport master (
        output mix_start, voice_samples, voice_pan, voice_active, stereo_on, atten_shift,
        input  sample_left, sample_right, sample_mono, sample_valid, busy, clip, overrun
    );

    modport slave (
        input  mix_start, voice_samples, voice_pan, voice_active, stereo_on, atten_shift,
        output sample_left, sample_right, sample_mono, sample_valid, busy, clip, overrun
    );
endinterface

// File: rtl/voice_mixer.sv
// Time-multiplexed L/R/mono voice mixer with per-voice pan, attenuation and saturation.
// Latency: result and sample_valid NUM_VOICES+1 cycles after the mix_start edge.
// Backpressure: none; mix_start while busy is dropped and latched in sticky overrun.
module voice_mixer #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    voice_mixer_if.slave  mix
);
    localparam int ACC_W = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (SAMPLE_WIDTH - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                             state;
    logic [IDX_W-1:0]                   idx;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] cap_samples;
    logic [2*NUM_VOICES-1:0]            cap_pan;
    logic [NUM_VOICES-1:0]              cap_active;
    logic                               cap_stereo;
    logic [2:0]                         cap_atten;
    logic signed [ACC_W-1:0]            acc_l;
    logic signed [ACC_W-1:0]            acc_r;
    logic signed [ACC_W-1:0]            acc_m;

    logic signed [ACC_W-1:0]            cur_ext;
    logic [1:0]                         cur_pan;
    logic                               add_m;
    logic                               add_l;
    logic                               add_r;
    logic [SAMPLE_WIDTH:0]              sat_l;
    logic [SAMPLE_WIDTH:0]              sat_r;
    logic [SAMPLE_WIDTH:0]              sat_m;

    // Returns {clipped, value}: floor shift first, then clamp to the output range.
    function automatic logic [SAMPLE_WIDTH:0] saturate(input logic signed [ACC_W-1:0] sum,
                                                       input logic [2:0] sh);
        logic signed [ACC_W-1:0] shifted;
        shifted = sum >>> sh;
        if (shifted > SAT_MAX) begin
            return {1'b1, SAT_MAX[SAMPLE_WIDTH-1:0]};
        end else if (shifted < SAT_MIN) begin
            return {1'b1, SAT_MIN[SAMPLE_WIDTH-1:0]};
        end else begin
            return {1'b0, shifted[SAMPLE_WIDTH-1:0]};
        end
    endfunction

    // The capture registers shift down one voice per ACCUM cycle, so slot 0 is always current.
    always_comb begin
        cur_ext = {{(ACC_W-SAMPLE_WIDTH){cap_samples[SAMPLE_WIDTH-1]}},
                   cap_samples[SAMPLE_WIDTH-1:0]};
        cur_pan = cap_pan[1:0];
        add_m   = cap_active[0] && (cur_pan != 2'b11);
        add_l   = add_m && (!cap_stereo || (cur_pan != 2'b10));
        add_r   = add_m && (!cap_stereo || (cur_pan != 2'b01));
        sat_l   = saturate(acc_l, cap_atten);
        sat_r   = saturate(acc_r, cap_atten);
        sat_m   = saturate(acc_m, cap_atten);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            cap_samples      <= '0;
            cap_pan          <= '0;
            cap_active       <= '0;
            cap_stereo       <= 1'b0;
            cap_atten        <= '0;
            acc_l            <= '0;
            acc_r            <= '0;
            acc_m            <= '0;
            mix.sample_left  <= '0;
            mix.sample_right <= '0;
            mix.sample_mono  <= '0;
            mix.sample_valid <= 1'b0;
            mix.busy         <= 1'b0;
            mix.clip         <= 1'b0;
            mix.overrun      <= 1'b0;
        end else begin
            mix.sample_valid <= 1'b0;
            if (mix.mix_start && (state != IDLE)) begin
                mix.overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mix.mix_start) begin
                        cap_samples <= mix.voice_samples;
                        cap_pan     <= mix.voice_pan;
                        cap_active  <= mix.voice_active;
                        cap_stereo  <= mix.stereo_on;
                        cap_atten   <= mix.atten_shift;
                        acc_l       <= '0;
                        acc_r       <= '0;
                        acc_m       <= '0;
                        idx         <= '0;
                        mix.busy    <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (add_l) acc_l <= acc_l + cur_ext;
                    if (add_r) acc_r <= acc_r + cur_ext;
                    if (add_m) acc_m <= acc_m + cur_ext;
                    cap_samples <= cap_samples >> SAMPLE_WIDTH;
                    cap_pan     <= cap_pan >> 2;
                    cap_active  <= cap_active >> 1;
                    idx         <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    mix.sample_left  <= sat_l[SAMPLE_WIDTH-1:0];
                    mix.sample_right <= sat_r[SAMPLE_WIDTH-1:0];
                    mix.sample_mono  <= sat_m[SAMPLE_WIDTH-1:0];
                    mix.clip         <= sat_l[SAMPLE_WIDTH] | sat_r[SAMPLE_WIDTH] | sat_m[SAMPLE_WIDTH];
                    mix.sample_valid <= 1'b1;
                    mix.busy         <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mix.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised, time-multiplexed mixer that sums NUM_VOICES signed note-player samples into left, right and mono outputs, with per-voice panning, a stereo on/off mode, a master attenuation shift and saturation. It sits between the note players and the codec conditioners. It generalises the fixed three-voice combinational stereo sum to any voice count. Each sample it produces carries a valid pulse and an overrun/clip status.

## Interface
- NUM_VOICES, 3, number of voice inputs (1..16)
- SAMPLE_WIDTH, 16, signed two's-complement sample width for inputs and outputs
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- mix_start  in  1  one-cycle request to mix a new sample; normally driven by generate_next_sample
- voice_samples  in  NUM_VOICES*SAMPLE_WIDTH  voice i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- voice_pan  in  2*NUM_VOICES  per-voice pan: 00 center, 01 left only, 10 right only, 11 muted
- voice_active  in  NUM_VOICES  1 = voice contributes; 0 = contributes zero
- stereo_on  in  1  0 = every unmuted voice is treated as center
- atten_shift  in  3  arithmetic right shift applied to the sums before saturation
- sample_left / sample_right / sample_mono  out  SAMPLE_WIDTH each  mixed outputs
- sample_valid  out  1  one-cycle pulse when the outputs update
- busy  out  1  mix in progress
- clip  out  1  at least one output saturated in the current sample; valid alongside the outputs
- overrun  out  1  sticky: mix_start arrived while busy

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE, mix_start=1:
  - Snapshot voice_samples, voice_pan, voice_active, stereo_on and atten_shift into capture registers.
  - Clear the L, R and M accumulators and the voice index.
  - Go to ACCUM.
- ACCUM: one voice per cycle, index 0..NUM_VOICES-1, using the sign-extended sample.
  - Inactive or pan=11: no contribution.
  - Otherwise M += sample.
  - Center, or stereo_on=0: L += sample and R += sample.
  - Pan=01 with stereo_on=1: L only. Pan=10 with stereo_on=1: R only.
  - After index NUM_VOICES-1, go to DONE.
- Accumulator width: SAMPLE_WIDTH + clog2(NUM_VOICES) + 1. Accumulators never overflow internally.
- DONE:
  - Arithmetic right shift of each sum by atten_shift (floor toward -inf).
  - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Register the three outputs, set clip if any saturated, pulse sample_valid.
  - Return to IDLE.
- Outputs and clip hold their values between sample_valid pulses.
- Inputs may change freely after mix_start is accepted; only the snapshot is used.

## Timing
- Reset values: all sample outputs 0, sample_valid 0, busy 0, clip 0, overrun 0; state IDLE.
- Latency:
  - mix_start is sampled at edge E.
  - Outputs and sample_valid=1 are visible after edge E+NUM_VOICES+1.
  - sample_valid stays high for exactly one cycle.
- busy is high from the cycle after E until the cycle sample_valid is high; busy is 0 in that cycle.
- Back-to-back requests: mix_start is accepted in the same cycle sample_valid is high. The minimum start spacing is NUM_VOICES+1 cycles.
- mix_start while busy:
  - The request is ignored and the current mix is unaffected.
  - overrun is set and stays at 1 until reset.
- Reset mid-mix: abort immediately with no sample_valid. Outputs return to 0.
- reset has priority over mix_start in the same cycle.

## Test plan
- Pan/stereo, NUM_VOICES=4, atten 0, stereo_on=1:
  - Stimulus: v0=100 pan 01, v1=200 pan 10, v2=300 pan 00, v3=400 inactive.
  - Response: L=400, R=500, M=600, clip=0, sample_valid exactly 5 cycles after the start edge.
  - Repeat with stereo_on=0: L=R=M=600.
- Mute:
  - Stimulus: v2 pan changed to 11, stereo_on=1, rest as above.
  - Response: L=100, R=200, M=300.
- Saturation, four center voices:
  - 16'h7000 each gives L=R=M=16'h7FFF with clip=1.
  - 16'h9000 each gives 16'h8000 with clip=1.
  - A following mix of 0s gives 0 with clip=0.
- Attenuation, atten_shift=2:
  - Sum 1000 gives 250.
  - Sum -1001 gives -251.
- Overrun/back-to-back:
  - mix_start again 2 cycles after a start: ignored, overrun=1, first result unchanged.
  - mix_start in the sample_valid cycle: accepted, second valid exactly NUM_VOICES+1 cycles later.
- Reset mid-mix:
  - Stimulus: reset asserted during ACCUM.
  - Response: no sample_valid, outputs 0, busy 0, overrun 0; the next mix_start behaves normally.
